// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle: stage inputs from MEM plus the register-file write port,
// forwarding history and retired count driven back by the write-back stage.
interface wb_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  logic               stall_i;
  logic               flush_i;
  logic               valid_i;
  logic               wen_i;
  logic               ld_i;
  logic [2:0]         ld_type_i;
  logic [OFF_W-1:0]   byte_off_i;
  logic [RADDR_W-1:0] rd_i;
  logic [DATA_W-1:0]  alu_i;
  logic [DATA_W-1:0]  lmd_i;

  logic [DATA_W-1:0]  wb_data_o;
  logic [RADDR_W-1:0] wb_addr_o;
  logic               wb_write_o;
  logic               fwd_valid_o;
  logic [RADDR_W-1:0] fwd_addr_o;
  logic [DATA_W-1:0]  fwd_data_o;
  logic [CNT_W-1:0]   retired_o;

  modport master (
    output stall_i, flush_i, valid_i, wen_i, ld_i, ld_type_i, byte_off_i,
           rd_i, alu_i, lmd_i,
    input  wb_data_o, wb_addr_o, wb_write_o, fwd_valid_o, fwd_addr_o,
           fwd_data_o, retired_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, wen_i, ld_i, ld_type_i, byte_off_i,
           rd_i, alu_i, lmd_i,
    output wb_data_o, wb_addr_o, wb_write_o, fwd_valid_o, fwd_addr_o,
           fwd_data_o, retired_o
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register (falling-edge capture), sub-word load
// extraction, register-file write port, one-deep write history, retire counter.
module wb_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 32
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   typedef enum logic [2:0] {
      LD_W  = 3'b000,
      LD_H  = 3'b001,
      LD_HU = 3'b010,
      LD_B  = 3'b011,
      LD_BU = 3'b100
   } ld_type_e;

   logic               s_valid;
   logic               s_wen;
   logic               s_ld;
   logic [2:0]         s_ld_type;
   logic [OFF_W-1:0]   s_off;
   logic [RADDR_W-1:0] s_rd;
   logic [DATA_W-1:0]  s_alu;
   logic [DATA_W-1:0]  s_lmd;

   logic               h_valid;
   logic [RADDR_W-1:0] h_addr;
   logic [DATA_W-1:0]  h_data;
   logic [CNT_W-1:0]   retired;

   logic [OFF_W-1:0]   half_off;
   logic [7:0]         byte_v;
   logic [15:0]        half_v;
   logic [DATA_W-1:0]  ld_data;
   logic [DATA_W-1:0]  wb_data;
   logic               wb_write;

   // flush zeroes every stage field so a bubble also presents data/addr of 0
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         s_valid   <= 1'b0;
         s_wen     <= 1'b0;
         s_ld      <= 1'b0;
         s_ld_type <= '0;
         s_off     <= '0;
         s_rd      <= '0;
         s_alu     <= '0;
         s_lmd     <= '0;
      end else if (bus.flush_i) begin
         s_valid   <= 1'b0;
         s_wen     <= 1'b0;
         s_ld      <= 1'b0;
         s_ld_type <= '0;
         s_off     <= '0;
         s_rd      <= '0;
         s_alu     <= '0;
         s_lmd     <= '0;
      end else if (!bus.stall_i) begin
         s_valid   <= bus.valid_i;
         s_wen     <= bus.wen_i;
         s_ld      <= bus.ld_i;
         s_ld_type <= bus.ld_type_i;
         s_off     <= bus.byte_off_i;
         s_rd      <= bus.rd_i;
         s_alu     <= bus.alu_i;
         s_lmd     <= bus.lmd_i;
      end
   end

   // history samples the write port as it stood before the edge
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         h_valid <= 1'b0;
         h_addr  <= '0;
         h_data  <= '0;
      end else if (bus.flush_i || !bus.stall_i) begin
         h_valid <= wb_write;
         h_addr  <= s_rd;
         h_data  <= wb_data;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         retired <= '0;
      end else if (!bus.flush_i && !bus.stall_i && bus.valid_i) begin
         retired <= retired + CNT_W'(1);
      end
   end

   // halfword lane pair starts at an even lane; bit 0 of the offset is dropped
   always_comb begin
      half_off    = s_off;
      half_off[0] = 1'b0;
      byte_v      = s_lmd[{s_off, 3'b000} +: 8];
      half_v      = s_lmd[{half_off, 3'b000} +: 16];
   end

   always_comb begin
      ld_data = s_lmd;
      case (ld_type_e'(s_ld_type))
         LD_B:    ld_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
         LD_BU:   ld_data = {{(DATA_W-8){1'b0}}, byte_v};
         LD_H:    ld_data = {{(DATA_W-16){half_v[15]}}, half_v};
         LD_HU:   ld_data = {{(DATA_W-16){1'b0}}, half_v};
         default: ld_data = s_lmd;
      endcase
   end

   always_comb begin
      wb_data  = s_ld ? ld_data : s_alu;
      wb_write = s_valid & s_wen & (s_rd != '0);
   end

   assign bus.wb_data_o   = wb_data;
   assign bus.wb_addr_o   = s_rd;
   assign bus.wb_write_o  = wb_write;
   assign bus.fwd_valid_o = h_valid;
   assign bus.fwd_addr_o  = h_addr;
   assign bus.fwd_data_o  = h_data;
   assign bus.retired_o   = retired;
endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back pipeline stage for the five-stage MIPS-style core, sitting between the MEM stage and the register file. It holds the MEM/WB pipeline register and supports stall and flush. It extracts and sign- or zero-extends sub-word load data, and generates the register-file write port. It also provides a one-deep forwarding history of the last retired write and a retired-instruction counter.

## Interface
- DATA_W, 32, datapath width; multiple of 8, at least 16
- RADDR_W, 5, register address width
- CNT_W, 32, retired-instruction counter width
- OFF_W (localparam), $clog2(DATA_W/8), byte-offset width
- clk  in  1  stage clock; pipeline register captures on falling edge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold current contents
- flush_i  in  1  insert bubble; has priority over stall_i
- valid_i  in  1  MEM stage carries a real instruction
- wen_i  in  1  instruction writes a register
- ld_i  in  1  1 = result from load data, 0 = result from ALU
- ld_type_i  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes behave as LW
- byte_off_i  in  OFF_W  low address bits of the load
- rd_i  in  RADDR_W  destination register (rt or rd, already selected by MEM)
- alu_i  in  DATA_W  ALU result
- lmd_i  in  DATA_W  raw memory word
- wb_data_o  out  DATA_W  register-file write data
- wb_addr_o  out  RADDR_W  register-file write address
- wb_write_o  out  1  register-file write enable
- fwd_valid_o  out  1  history entry is a real write
- fwd_addr_o  out  RADDR_W  history entry address
- fwd_data_o  out  DATA_W  history entry data
- retired_o  out  CNT_W  count of valid instructions captured

## Operation
- Stored state:
  - Stage register: valid, wen, ld, ld_type, byte_off, rd, alu, lmd.
  - History register: fwd_valid, fwd_addr, fwd_data.
  - retired counter.
- Priority at each falling edge:
  - flush_i: stage valid <- 0, other stage fields <- 0. History <- outgoing stage entry. Counter unchanged.
  - else stall_i: all state held. History and counter unchanged.
  - else: stage <- inputs. History <- outgoing stage entry. Counter += 1 if valid_i.
- Outgoing stage entry (history update): fwd_valid <- (wb_write_o). fwd_addr <- wb_addr_o. fwd_data <- wb_data_o, all evaluated on the pre-edge contents.
- Load extraction is little-endian; byte lane k = lmd[8k+7:8k], k = byte_off.
  - LB/LBU: select lane byte_off. LB sign-extends bit 7 to DATA_W; LBU zero-extends.
  - LH/LHU: halfword at lanes {byte_off with bit0 forced 0, +1}; bit0 of byte_off ignored, no misalignment trap. LH sign-extends bit 15; LHU zero-extends.
  - LW: full lmd.
- Output mux and write-port rules:
  - wb_data_o = ld ? extracted load data : alu.
  - wb_addr_o = rd.
  - wb_write_o = valid & wen & (rd != 0). Register 0 is never written.
- During a stall, wb_write_o stays at its held value. The register file re-writes the identical value, which is idempotent.
- The counter wraps modulo 2^CNT_W.

## Timing
- Capture latency: an input is sampled at falling edge N. The write port reflects it from edge N until the next capturing edge. The register file writes on the following rising edge.
- Outputs are combinational from registered state only; there is no input-to-output combinational path.
- History lags the write port by exactly one capturing edge. This covers the case where a read in ID coincides with the cycle after a WB write.
- retired_o updates at the same edge that captures the instruction.
- Reset values, forced immediately on rst assertion, including mid-stall or mid-operation:
  - wb_data_o = 0, wb_addr_o = 0, wb_write_o = 0.
  - fwd_valid_o = 0, fwd_addr_o = 0, fwd_data_o = 0.
  - retired_o = 0.
- First capture after rst deassertion: the first falling edge with rst low.
- Flush and stall asserted together: flush wins; a bubble is inserted.

## Test plan
- ALU write: valid=1, wen=1, ld=0, rd=5, alu=0x1234_5678 -> after the falling edge, wb_write_o=1, wb_addr_o=5, wb_data_o=0x1234_5678, retired_o=1.
- Loads on lmd=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80; LBU off=3 -> 0x0000_0080.
  - LH off=1 -> 0x0000_7F01; LH off=2 -> 0xFFFF_80FF; LHU off=2 -> 0x0000_80FF.
  - LW -> 0x80FF_7F01.
- Register-0 suppression: wen=1, rd=0, alu=0xDEAD -> wb_write_o=0. The next capture gives fwd_valid_o=0. retired_o still increments.
- Stall/flush sequence:
  - Capture rd=7 (0xAA), then stall 3 cycles while inputs change -> outputs and retired_o are held.
  - Then flush+stall -> wb_write_o=0, and the history becomes valid with rd=7 and 0xAA.
- History chaining: write rd=3 (0x11) then rd=4 (0x22) on consecutive edges -> at the second edge, fwd = {1, 3, 0x11} and the write port = {1, 4, 0x22}.
- Reset and wrap:
  - Assert rst asynchronously between edges mid-stream -> all outputs go to 0 immediately.
  - With CNT_W=4, 17 valid captures -> retired_o=1.
